// File: rtl/ram8_if.sv
// Bus bundle for the eight-word register bank: write data, load, addresses and read data.
// Latency: none, wires only. The optional second read port exists only with RAM8_PORTB_EN.
// Backpressure: none. The bank always accepts a write and always answers a read.
interface ram8_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] in;
  logic             load;
  logic [2:0]       address;
  logic [WIDTH-1:0] out;
`ifdef RAM8_PORTB_EN
  logic [2:0]       addressB;
  logic [WIDTH-1:0] outB;
`endif

`ifdef RAM8_PORTB_EN
  modport master (
    output in,
    output load,
    output address,
    output addressB,
    input  out,
    input  outB
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    input  addressB,
    output out,
    output outB
  );
`else
  modport master (
    output in,
    output load,
    output address,
    input  out
  );

  modport slave (
    input  in,
    input  load,
    input  address,
    output out
  );
`endif

endinterface

// File: rtl/ram8.sv
// Eight-word WIDTH-bit register bank: one-hot write decode, combinational 8-way read mux.
// Latency: a write lands on the capturing clk edge and reads take zero cycles. Reset is async and clears all words.
// Backpressure: none. Optional macro RAM8_PORTB_EN adds an independent read port B (addressB/outB).
module ram8 #(
  parameter int WIDTH = 16
) (
  input  logic  clk,
  input  logic  reset,
  ram8_if.slave bus
);

  // Storage, packed so the whole bank is updated from a single process.
  logic [7:0][WIDTH-1:0] word_q;

  // One-hot write strobe. At most one bit is set per edge.
  logic [7:0] wr_en;

  // 8-way selection. An unknown address falls through to X, so a
  // corrupted address is visible on the read port rather than aliasing
  // onto some word.
  function automatic logic [WIDTH-1:0] sel8(
    input logic [2:0]            a,
    input logic [7:0][WIDTH-1:0] w
  );
    case (a)
      3'd0:    return w[0];
      3'd1:    return w[1];
      3'd2:    return w[2];
      3'd3:    return w[3];
      3'd4:    return w[4];
      3'd5:    return w[5];
      3'd6:    return w[6];
      3'd7:    return w[7];
      default: return 'x;
    endcase
  endfunction

  // Address decoder. An X/Z address compares as unknown, so no strobe
  // is raised and no word is touched.
  always_comb begin
    wr_en = '0;
    if (bus.load) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.address == 3'(i)) begin
          wr_en[i] = 1'b1;
        end
      end
    end
  end

  // Word registers. Reset wins over any write pending in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wr_en[i]) begin
          word_q[i] <= bus.in;
        end
      end
    end
  end

  // Read port A. This path has no bypass from in: a read of the word
  // being written shows the old value until the edge.
  always_comb begin
    bus.out = sel8(bus.address, word_q);
  end

`ifdef RAM8_PORTB_EN
  // Read port B. This port is fully independent of port A and follows the same old-then-new rule.
  always_comb begin
    bus.outB = sel8(bus.addressB, word_q);
  end
`endif

endmodule

// File: tb/tb_ram8.sv
// Directed self-checking bench for ram8: reset, sweep, isolation, read-during-write, hold, port B.
// Latency: inputs change 1ns after a rising edge, outputs are sampled before the next edge.
// Backpressure: none; every step is a bounded number of clock edges.
module tb_ram8;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ram8_if #(.WIDTH(16)) bus ();

  ram8 #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs are driven away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    bus.address = a;
    bus.in      = d;
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    check(tag, bus.out, exp);
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    reset       = 1'b1;
    bus.in      = '0;
    bus.load    = 1'b0;
    bus.address = '0;
`ifdef RAM8_PORTB_EN
    bus.addressB = '0;
`endif

    // Reset state: every address reads zero.
    #3;
    for (int i = 0; i < 8; i++) rd($sformatf("reset_state_%0d", i), 3'(i), 16'h0000);
    tick();
    reset = 1'b0;

    // Fill with all-ones, then assert reset between edges.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF);
    rd("fill_ffff_0", 3'd0, 16'hFFFF);
    rd("fill_ffff_7", 3'd7, 16'hFFFF);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) rd($sformatf("async_reset_%0d", i), 3'(i), 16'h0000);

    // A write attempted while reset is high is ignored.
    wr(3'd1, 16'hABCD);
    rd("write_in_reset", 3'd1, 16'h0000);
    reset = 1'b0;

    // Write/read sweep. Each value must be visible right after its edge.
    for (int i = 0; i < 8; i++) begin
      wr(3'(i), 16'(16'h1111 * i));
      check($sformatf("sweep_wlat_%0d", i), bus.out, 16'(16'h1111 * i));
    end
    for (int i = 0; i < 8; i++) rd($sformatf("sweep_rd_%0d", i), 3'(i), 16'(16'h1111 * i));
    for (int i = 7; i >= 0; i--) rd($sformatf("sweep_rev_%0d", i), 3'(i), 16'(16'h1111 * i));

    // Isolation: touching 3 and 4 leaves every other word alone.
    wr(3'd3, 16'hA5A5);
    wr(3'd4, 16'h5A5A);
    rd("iso_3", 3'd3, 16'hA5A5);
    rd("iso_4", 3'd4, 16'h5A5A);
    for (int i = 0; i < 8; i++) begin
      if (i != 3 && i != 4) rd($sformatf("iso_other_%0d", i), 3'(i), 16'(16'h1111 * i));
    end

    // Read-during-write at address 5: old before the edge, new after.
    wr(3'd5, 16'h0001);
    bus.address = 3'd5;
    bus.in      = 16'h0002;
    bus.load    = 1'b1;
    #1;
    check("rdw_before", bus.out, 16'h0001);
    tick();
    check("rdw_after", bus.out, 16'h0002);
    bus.load = 1'b0;

    // load=0 hold at address 2 for four edges.
    bus.address = 3'd2;
    bus.in      = 16'hDEAD;
    bus.load    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("hold_%0d", i), bus.out, 16'h2222);
    end

    // Back-to-back writes to address 6: each value lasts one cycle, and the last write wins.
    bus.address = 3'd6;
    bus.load    = 1'b1;
    bus.in      = 16'h0AAA;
    tick();
    check("b2b_1", bus.out, 16'h0AAA);
    bus.in = 16'h0BBB;
    tick();
    check("b2b_2", bus.out, 16'h0BBB);
    bus.in = 16'h0CCC;
    tick();
    check("b2b_3", bus.out, 16'h0CCC);
    bus.load = 1'b0;
    tick();
    check("b2b_last", bus.out, 16'h0CCC);
    rd("b2b_neighbour_7", 3'd7, 16'h7777);

    // Address wrap from 7 to 0 is plain 3-bit arithmetic.
    rd("wrap_7", 3'd7, 16'h7777);
    rd("wrap_0", 3'd0, 16'h0000);

`ifdef RAM8_PORTB_EN
    // Port B watches word 7 while port A writes it.
    bus.addressB = 3'd7;
    bus.address  = 3'd7;
    bus.in       = 16'h1234;
    bus.load     = 1'b1;
    #1;
    check("portb_before", bus.outB, 16'h7777);
    tick();
    check("portb_after", bus.outB, 16'h1234);
    bus.load = 1'b0;
    // Independence: A and B on different words at the same time.
    bus.address  = 3'd3;
    bus.addressB = 3'd1;
    #1;
    check("portb_indep_a", bus.out, 16'hA5A5);
    check("portb_indep_b", bus.outB, 16'h1111);
    bus.addressB = 3'd4;
    #1;
    check("portb_indep_b4", bus.outB, 16'h5A5A);
    check("portb_indep_a_hold", bus.out, 16'hA5A5);
`endif

    // A final reset clears everything again.
    reset = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) rd($sformatf("final_reset_%0d", i), 3'(i), 16'h0000);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
